hh_neuron_array: RTL and testbench

HH_NEURON_ARRAY -- requirements
Module: hh_neuron_array

---
 rtl/hh_neuron_array.sv | 172 +++++++++++++++++
 tb/tb_hh_neuron_array.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hh_neuron_array.sv
// hh_neuron_array
//   Time-multiplexed array of N_CH leaky integrate-and-fire neurons. Each
//   step request starts one sweep that updates channels 0..N_CH-1, one per
//   clock. A channel leaks v >> LEAK_SHIFT, adds its input current and
//   saturates at 2^W-1. Reaching THRESH fires a spike, zeroes the membrane
//   and holds it at zero for REFRAC following steps.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset; aborts a sweep in progress
//   cur_wr_en    write strobe for a channel's input current register
//   cur_wr_addr  channel index for the current write (out-of-range ignored)
//   cur_wr_data  input current value
//   step         start a sweep (honoured only while idle)
//   busy         high from the first sweep cycle through the done cycle
//   done         one-cycle pulse at sweep completion
//   spike        per-channel spike flags of the last completed sweep
//   spike_count  saturating count of all spikes since reset
//   rd_addr      membrane readout channel select
//   rd_vmem      membrane potential of channel rd_addr, one cycle later
module hh_neuron_array #(
  parameter int N_CH       = 4,
  parameter int W          = 12,
  parameter int LEAK_SHIFT = 3,
  parameter int THRESH     = 1024,
  parameter int REFRAC     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cur_wr_en,
  input  logic [$clog2(N_CH)-1:0] cur_wr_addr,
  input  logic [W-1:0]            cur_wr_data,
  input  logic                    step,
  output logic                    busy,
  output logic                    done,
  output logic [N_CH-1:0]         spike,
  output logic [15:0]             spike_count,
  input  logic [$clog2(N_CH)-1:0] rd_addr,
  output logic [W-1:0]            rd_vmem
);

  localparam int AW    = $clog2(N_CH);
  localparam int DEPTH = 1 << AW;
  localparam logic [W-1:0]  THRESH_W = W'(THRESH);
  localparam logic [3:0]    REFRAC_W = 4'(REFRAC);
  localparam logic [AW-1:0] LAST_CH  = AW'(N_CH - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t            state_reg;
  logic [AW-1:0]     ch_idx_reg;
  logic [N_CH-1:0]   shadow_reg;
  logic [N_CH-1:0]   fire;          // spike of the channel processed this cycle
  logic [N_CH-1:0]   spike_next;
  logic [4:0]        pop;
  logic [16:0]       count_sum;
  logic [W-1:0]      v_rd [DEPTH];  // padded to a power of two for readout

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [W-1:0] v_reg;
      logic [W-1:0] i_reg;
      logic [3:0]   refrac_reg;
      logic [W:0]   sum;
      logic [W-1:0] v_next;
      logic         sel;
      logic         wr_hit;

      assign sel    = (state_reg == SWEEP) && (ch_idx_reg == AW'(gi));
      // Only existing channels decode, so addresses >= N_CH hit nothing.
      assign wr_hit = cur_wr_en && (cur_wr_addr == AW'(gi));

      // Leak never underflows, so only the current addition can overflow.
      always_comb begin
        sum    = {1'b0, v_reg - (v_reg >> LEAK_SHIFT)} + {1'b0, i_reg};
        v_next = sum[W] ? {W{1'b1}} : sum[W-1:0];
      end

      assign fire[gi] = sel && (refrac_reg == 4'd0) && (v_next >= THRESH_W);

      // The update reads i_reg before a same-cycle write lands.
      always_ff @(posedge clk) begin
        if (rst) begin
          v_reg      <= '0;
          i_reg      <= '0;
          refrac_reg <= '0;
        end else begin
          if (wr_hit) begin
            i_reg <= cur_wr_data;
          end
          if (sel) begin
            if (refrac_reg != 4'd0) begin
              v_reg      <= '0;
              refrac_reg <= refrac_reg - 4'd1;
            end else if (v_next >= THRESH_W) begin
              v_reg      <= '0;
              refrac_reg <= REFRAC_W;
            end else begin
              v_reg <= v_next;
            end
          end
        end
      end
    end

    for (gi = 0; gi < DEPTH; gi++) begin : g_rd
      if (gi < N_CH) begin : g_live
        assign v_rd[gi] = g_ch[gi].v_reg;
      end else begin : g_pad
        assign v_rd[gi] = '0;
      end
    end
  endgenerate

  // Final flags include the last channel, processed in the same cycle.
  assign spike_next = shadow_reg | fire;

  always_comb begin
    pop = '0;
    for (int k = 0; k < N_CH; k++) begin
      pop = pop + 5'(spike_next[k]);
    end
    count_sum = {1'b0, spike_count} + 17'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      ch_idx_reg  <= '0;
      shadow_reg  <= '0;
      spike       <= '0;
      spike_count <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_vmem     <= '0;
    end else begin
      rd_vmem <= v_rd[rd_addr];
      done    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (step) begin
            state_reg  <= SWEEP;
            busy       <= 1'b1;
            ch_idx_reg <= '0;
            shadow_reg <= '0;
          end
        end
        SWEEP: begin
          shadow_reg <= spike_next;
          if (ch_idx_reg == LAST_CH) begin
            state_reg   <= DONE;
            done        <= 1'b1;
            spike       <= spike_next;
            spike_count <= count_sum[16] ? 16'hFFFF : count_sum[15:0];
          end else begin
            ch_idx_reg <= ch_idx_reg + AW'(1);
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hh_neuron_array.sv
module tb_hh_neuron_array;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // instance a: default parameters
  logic        a_wr_en;
  logic [1:0]  a_wr_addr;
  logic [11:0] a_wr_data;
  logic        a_step, a_busy, a_done;
  logic [3:0]  a_spike;
  logic [15:0] a_cnt;
  logic [1:0]  a_rd_addr;
  logic [11:0] a_rd_vmem;
  // instance b: three channels, threshold 4095
  logic        b_wr_en;
  logic [1:0]  b_wr_addr;
  logic [11:0] b_wr_data;
  logic        b_step, b_busy, b_done;
  logic [2:0]  b_spike;
  logic [15:0] b_cnt;
  logic [1:0]  b_rd_addr;
  logic [11:0] b_rd_vmem;

  hh_neuron_array dut_a (
    .clk(clk), .rst(rst), .cur_wr_en(a_wr_en), .cur_wr_addr(a_wr_addr),
    .cur_wr_data(a_wr_data), .step(a_step), .busy(a_busy), .done(a_done),
    .spike(a_spike), .spike_count(a_cnt), .rd_addr(a_rd_addr), .rd_vmem(a_rd_vmem)
  );

  hh_neuron_array #(.N_CH(3), .THRESH(4095)) dut_b (
    .clk(clk), .rst(rst), .cur_wr_en(b_wr_en), .cur_wr_addr(b_wr_addr),
    .cur_wr_data(b_wr_data), .step(b_step), .busy(b_busy), .done(b_done),
    .spike(b_spike), .spike_count(b_cnt), .rd_addr(b_rd_addr), .rd_vmem(b_rd_vmem)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference state for instance a
  int mv[N];
  int mi[N];
  int mr[N];
  int mspk;
  int mcnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      mv[c] = 0; mi[c] = 0; mr[c] = 0;
    end
    mspk = 0;
    mcnt = 0;
  endfunction

  // One integration step over every channel, straight from the neuron rules.
  function automatic void model_step();
    int nx;
    mspk = 0;
    for (int c = 0; c < N; c++) begin
      if (mr[c] > 0) begin
        mv[c] = 0;
        mr[c] = mr[c] - 1;
      end else begin
        nx = mv[c] - (mv[c] / 8) + mi[c];
        if (nx > 4095) nx = 4095;
        if (nx >= 1024) begin
          mspk  = mspk | (1 << c);
          mv[c] = 0;
          mr[c] = 2;
        end else begin
          mv[c] = nx;
        end
      end
    end
    mcnt = mcnt + $countones(mspk[N-1:0]);
    if (mcnt > 65535) mcnt = 65535;
  endfunction

  task automatic wr_a(input int addr, input int data);
    a_wr_en   = 1'b1;
    a_wr_addr = addr[1:0];
    a_wr_data = data[11:0];
    @(negedge clk);
    a_wr_en = 1'b0;
    mi[addr] = data;
  endtask

  task automatic check_vmem_a(input string tag);
    for (int c = 0; c < N; c++) begin
      a_rd_addr = c[1:0];
      @(negedge clk);
      $display("%s: rd ch%0d vmem=%0d model=%0d", tag, c, a_rd_vmem, mv[c]);
      check({tag, "_vmem"}, 32'(a_rd_vmem), mv[c]);
    end
  endtask

  // Run one sweep on instance a; optionally rewrite ch0's current during the
  // cycle ch0 is processed (the step must still use the old current).
  task automatic sweep_a(input string tag, input bit mid_wr, input int mid_val);
    int lat, bc;
    a_step = 1'b1;
    @(negedge clk);
    a_step = 1'b0;
    lat = 0;
    bc  = 0;
    model_step();
    for (int k = 1; k <= 20; k++) begin
      if (k == 1 && mid_wr) begin
        a_wr_en = 1'b1; a_wr_addr = 2'd0; a_wr_data = mid_val[11:0];
      end
      if (k == 2) a_wr_en = 1'b0;
      if (a_busy) bc++;
      if (a_done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    a_wr_en = 1'b0;
    if (mid_wr) mi[0] = mid_val;
    $display("%s: done latency=%0d busy=%0d spike=%b count=%0d", tag, lat, bc, a_spike, a_cnt);
    check({tag, "_latency"}, lat, N + 1);
    check({tag, "_busy_len"}, bc, N + 1);
    check({tag, "_spike"}, 32'(a_spike), mspk);
    check({tag, "_count"}, 32'(a_cnt), mcnt);
    @(negedge clk);
    check({tag, "_idle_busy"}, 32'(a_busy), 0);
    check_vmem_a(tag);
    check({tag, "_spike_hold"}, 32'(a_spike), mspk);
  endtask

  task automatic sweep_b(input string tag);
    int lat;
    b_step = 1'b1;
    @(negedge clk);
    b_step = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (b_done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    $display("%s: done latency=%0d spike=%b count=%0d", tag, lat, b_spike, b_cnt);
    check({tag, "_latency"}, lat, 4);
    @(negedge clk);
  endtask

  task automatic rd_b(input int ch, input int exp, input string tag);
    b_rd_addr = ch[1:0];
    @(negedge clk);
    $display("%s: rd ch%0d vmem=%0d exp=%0d", tag, ch, b_rd_vmem, exp);
    check(tag, 32'(b_rd_vmem), exp);
  endtask

  int exp_v032[6] = '{512, 960, 0, 0, 0, 512};

  initial begin
    int nd, last;
    rst = 1'b1;
    a_wr_en = 0; a_wr_addr = 0; a_wr_data = 0; a_step = 0; a_rd_addr = 0;
    b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0; b_step = 0; b_rd_addr = 0;
    model_reset();

    // reset state
    @(negedge clk);
    @(negedge clk);
    $display("reset: busy=%0d done=%0d spike=%b count=%0d vmem=%0d", a_busy, a_done, a_spike, a_cnt, a_rd_vmem);
    check("rst_busy", 32'(a_busy), 0);
    check("rst_done", 32'(a_done), 0);
    check("rst_spike", 32'(a_spike), 0);
    check("rst_count", 32'(a_cnt), 0);
    check("rst_vmem", 32'(a_rd_vmem), 0);
    rst = 1'b0;
    @(negedge clk);

    // all currents zero
    sweep_a("zero", 1'b0, 0);

    // ch0 constant drive through spike and refractory period
    wr_a(0, 512);
    for (int s = 0; s < 6; s++) begin
      sweep_a("drive512", 1'b0, 0);
      a_rd_addr = 2'd0;
      @(negedge clk);
      check("drive512_v0", 32'(a_rd_vmem), exp_v032[s]);
      check("drive512_spk0", 32'(a_spike[0]), (s == 2) ? 1 : 0);
    end
    check("drive512_count", 32'(a_cnt), 1);

    // saturating clamp at threshold 2^W-1, and out-of-range current write
    b_wr_en = 1'b1; b_wr_addr = 2'd1; b_wr_data = 12'd3000;
    @(negedge clk);
    b_wr_addr = 2'd3; b_wr_data = 12'd4000;
    @(negedge clk);
    b_wr_en = 1'b0;
    sweep_b("clamp_s1");
    check("clamp_s1_spike", 32'(b_spike), 0);
    rd_b(1, 3000, "clamp_s1_v1");
    rd_b(0, 0, "clamp_s1_v0");
    rd_b(2, 0, "clamp_s1_v2");
    sweep_b("clamp_s2");
    check("clamp_s2_spike", 32'(b_spike), 3'b010);
    check("clamp_s2_count", 32'(b_cnt), 1);
    rd_b(1, 0, "clamp_s2_v1");
    rd_b(3, 0, "oob_rd");

    // randomized currents, including same-cycle writes during processing
    for (int it = 0; it < 25; it++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) begin
        wr_a($urandom_range(0, N - 1), $urandom_range(0, 1300));
      end
      sweep_a("rand", ($urandom_range(0, 3) == 0), $urandom_range(0, 1300));
    end

    // step held every cycle: only idle-sampled steps start sweeps
    nd = 0;
    last = -1;
    a_step = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c == 20) a_step = 1'b0;
      @(negedge clk);
      if (a_done) begin
        $display("step_hold: done at cycle %0d", c);
        if (last >= 0) check("step_hold_gap", c - last, N + 2);
        last = c;
        nd++;
      end
    end
    a_step = 1'b0;
    for (int s = 0; s < 4; s++) model_step();
    check("step_hold_ndone", nd, 4);
    check("step_hold_spike", 32'(a_spike), mspk);
    check("step_hold_count", 32'(a_cnt), mcnt);
    check_vmem_a("step_hold");

    // reset during the second sweep cycle; also beats step and a current write
    wr_a(1, 700);
    a_step = 1'b1;
    @(negedge clk);
    a_step = 1'b0;
    check("abort_busy_pre", 32'(a_busy), 1);
    @(negedge clk);
    rst = 1'b1; a_step = 1'b1;
    a_wr_en = 1'b1; a_wr_addr = 2'd2; a_wr_data = 12'd100;
    @(negedge clk);
    rst = 1'b0; a_step = 1'b0; a_wr_en = 1'b0;
    model_reset();
    check("abort_busy", 32'(a_busy), 0);
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      if (a_done) nd++;
      @(negedge clk);
    end
    $display("abort: done pulses=%0d spike=%b count=%0d", nd, a_spike, a_cnt);
    check("abort_no_done", nd, 0);
    check("abort_spike", 32'(a_spike), 0);
    check("abort_count", 32'(a_cnt), 0);
    check_vmem_a("abort");
    sweep_a("after_abort", 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
